// File: rtl/top_top.sv
// bfloat16 log2(x): ROM lookup of log2(1.f), fixed-point sum, normalize and round to bfloat16.
// Optional macro FLOG_PIPE_REG_EN adds a register between the fixed-point sum and normalization.
module top_top #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sign,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [MAN_WIDTH-1:0] fractional,
  input  logic                 input_valid,
  output logic                 s_res_o,
  output logic [EXP_WIDTH-1:0] e_res_o,
  output logic [MAN_WIDTH-1:0] f_res_o,
  output logic                 valid_o
);

  // Elaboration-time log2(1 + idx/128) by repeated squaring, 32 result bits rounded to 16.
  function automatic logic [15:0] log2_frac(input int idx);
    logic [127:0] x;
    logic [31:0]  acc;
    x   = 128'(128 + idx) << 53;
    acc = '0;
    for (int b = 31; b >= 0; b--) begin
      x = (x * x) >> 60;
      if (x[61]) begin
        x      = x >> 1;
        acc[b] = 1'b1;
      end
    end
    return 16'((33'(acc) + 33'h0_0000_8000) >> 16);
  endfunction

  logic [15:0] rom [128];
  for (genvar g = 0; g < 128; g++) begin : g_rom
    localparam logic [15:0] ROM_VAL = log2_frac(g);
    assign rom[g] = ROM_VAL;
  end

  logic        in_spec;
  logic [15:0] in_spec_bits;

  always_comb begin
    in_spec      = 1'b1;
    in_spec_bits = 16'h7FC0;
    if (exponent == '0)
      in_spec_bits = 16'hFF80;
    else if (exponent == '1)
      in_spec_bits = (fractional == '0 && !sign) ? 16'h7F80 : 16'h7FC0;
    else if (!sign)
      in_spec = 1'b0;
  end

  logic        s1_valid, s1_spec;
  logic [15:0] s1_spec_bits;
  logic [23:0] s1_sum;

  // Integer part in two's complement concatenated with the unsigned ROM fraction.
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= input_valid;
    s1_spec      <= in_spec;
    s1_spec_bits <= in_spec_bits;
    s1_sum       <= {exponent - EXP_WIDTH'(127), rom[fractional]};
  end

  logic        s2_valid, s2_spec;
  logic [15:0] s2_spec_bits;
  logic [23:0] s2_sum;

`ifdef FLOG_PIPE_REG_EN
  always_ff @(posedge clk) begin
    if (rst) s2_valid <= 1'b0;
    else     s2_valid <= s1_valid;
    s2_spec      <= s1_spec;
    s2_spec_bits <= s1_spec_bits;
    s2_sum       <= s1_sum;
  end
`else
  assign s2_valid     = s1_valid;
  assign s2_spec      = s1_spec;
  assign s2_spec_bits = s1_spec_bits;
  assign s2_sum       = s1_sum;
`endif

  logic [22:0] mag;
  logic [4:0]  lead;
  logic [22:0] norm;

  // |sum| < 2^23, so the magnitude fits 23 bits; the shift drops the leading one.
  always_comb begin
    mag  = s2_sum[23] ? (~s2_sum[22:0] + 23'd1) : s2_sum[22:0];
    lead = '0;
    for (int i = 0; i < 23; i++)
      if (mag[i]) lead = 5'(i);
    norm = mag << (5'd23 - lead);
  end

  logic        n_valid, n_spec, n_sign, n_zero, n_guard, n_sticky;
  logic [15:0] n_spec_bits;
  logic [7:0]  n_exp;
  logic [6:0]  n_frac;

  always_ff @(posedge clk) begin
    if (rst) n_valid <= 1'b0;
    else     n_valid <= s2_valid;
    n_spec      <= s2_spec;
    n_spec_bits <= s2_spec_bits;
    n_sign      <= s2_sum[23];
    n_zero      <= (mag == '0);
    n_exp       <= {3'b000, lead} + 8'd111;
    n_frac      <= norm[22:16];
    n_guard     <= norm[15];
    n_sticky    <= |norm[14:0];
  end

  logic       round_up;
  logic [7:0] frac_r;
  logic [7:0] exp_r;

  always_comb begin
    round_up = n_guard & (n_sticky | n_frac[0]);
    frac_r   = {1'b0, n_frac} + {7'd0, round_up};
    exp_r    = n_exp + {7'd0, frac_r[7]};
  end

  // Result fields only change when a valid result retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      s_res_o <= 1'b0;
      e_res_o <= '0;
      f_res_o <= '0;
    end else begin
      valid_o <= n_valid;
      if (n_valid) begin
        if (n_spec) begin
          s_res_o <= n_spec_bits[15];
          e_res_o <= n_spec_bits[14:7];
          f_res_o <= n_spec_bits[6:0];
        end else if (n_zero) begin
          s_res_o <= 1'b0;
          e_res_o <= '0;
          f_res_o <= '0;
        end else begin
          s_res_o <= n_sign;
          e_res_o <= exp_r;
          f_res_o <= frac_r[6:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_top_top.sv
// Randomized self-checking bench for top_top against a real-arithmetic log2 reference.
module tb_top_top;

`ifdef FLOG_PIPE_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sign;
  logic [7:0] exponent;
  logic [6:0] fractional;
  logic       input_valid;
  logic       s_res_o;
  logic [7:0] e_res_o;
  logic [6:0] f_res_o;
  logic       valid_o;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic        pipe_v [LAT];
  logic [15:0] pipe_d [LAT];
  logic        exp_valid = 1'b0;
  logic [15:0] exp_held  = 16'h0000;

  top_top #(.EXP_WIDTH(8), .MAN_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .sign(sign), .exponent(exponent), .fractional(fractional),
    .input_valid(input_valid), .s_res_o(s_res_o), .e_res_o(e_res_o), .f_res_o(f_res_o),
    .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  // Reference: log2 in real arithmetic, then round the fixed-point sum to 7 bits (RNE).
  function automatic logic [15:0] ref_log2(input logic [15:0] x);
    int  e, f, rom, sum, mag, p, sh, q, rem, half;
    logic neg;
    real r;
    e = int'(x[14:7]);
    f = int'(x[6:0]);
    if (e == 0) return 16'hFF80;
    if (e == 255) return (f == 0 && !x[15]) ? 16'h7F80 : 16'h7FC0;
    if (x[15]) return 16'h7FC0;
    r   = $ln(1.0 + real'(f) / 128.0) / $ln(2.0);
    rom = $rtoi($floor(r * 65536.0 + 0.5));
    sum = (e - 127) * 65536 + rom;
    if (sum == 0) return 16'h0000;
    neg = (sum < 0);
    mag = neg ? -sum : sum;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    sh = p - 7;
    if (sh > 0) begin
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
    end else begin
      q = mag << (-sh);
    end
    if (q == 256) begin
      q = 128;
      p++;
    end
    return {neg, 8'(p + 111), 7'(q)};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cycle, got, want);
    end
  endtask

  // One clock cycle: drive, advance the model at the edge, check at the falling edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] bits,
                               input logic [15:0] want);
    rst         = r;
    input_valid = v;
    sign        = bits[15];
    exponent    = bits[14:7];
    fractional  = bits[6:0];
    @(posedge clk);
    cycle++;
    if (r) begin
      for (int i = 0; i < LAT; i++) pipe_v[i] = 1'b0;
      exp_valid = 1'b0;
      exp_held  = 16'h0000;
    end else begin
      exp_valid = pipe_v[LAT-1];
      if (pipe_v[LAT-1]) exp_held = pipe_d[LAT-1];
      for (int i = LAT - 1; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_d[i] = pipe_d[i-1];
      end
      pipe_v[0] = v;
      pipe_d[0] = want;
    end
    @(negedge clk);
    checkOutput("valid_o", {15'd0, valid_o}, {15'd0, exp_valid});
    checkOutput("result", {s_res_o, e_res_o, f_res_o}, exp_held);
  endtask

  logic [15:0] dir_in  [9] = '{16'h72AD, 16'h47FA, 16'h3F80, 16'h3F00, 16'h0000,
                               16'hBF80, 16'h7F80, 16'hFF80, 16'h0042};
  logic [15:0] dir_out [9] = '{16'h42CD, 16'h4188, 16'h0000, 16'hBF80, 16'hFF80,
                               16'h7FC0, 16'h7F80, 16'h7FC0, 16'hFF80};

  initial begin
    logic [15:0] bits;
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = 16'h0000;
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'h3F00, 16'hBF80);

    // Directed examples issued back to back, then drained.
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, dir_in[i], dir_out[i]);
    for (int i = 0; i < LAT + 1; i++) applyStimulus(1'b0, 1'b0, 16'h3F80, 16'h0000);

    // Reset while two operands are in flight.
    applyStimulus(1'b0, 1'b1, 16'h47FA, 16'h4188);
    applyStimulus(1'b0, 1'b1, 16'h3F00, 16'hBF80);
    applyStimulus(1'b1, 1'b1, 16'h72AD, 16'h42CD);
    for (int i = 0; i < LAT + 1; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);

    // Random traffic, mostly positive normals, occasional reset.
    for (int n = 0; n < 600; n++) begin
      bits = 16'($urandom);
      if ($urandom_range(3) != 0) bits[15] = 1'b0;
      if ($urandom_range(9) == 0) bits[14:7] = ($urandom_range(1) == 0) ? 8'h00 : 8'hFF;
      applyStimulus($urandom_range(49) == 0, $urandom_range(4) != 0, bits, ref_log2(bits));
    end
    for (int i = 0; i < LAT + 1; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
